// File: rtl/mat2x2_stream_mac_pkg.sv
// Shared constants, FSM state encoding and packed-slot mapping for the 2x2 streaming MAC.
package mat2x2_pkg;

  localparam int N         = 2;
  localparam int ELEMS_IN  = 8;
  localparam int ELEMS_OUT = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Slot 3 is the MSB element of the packed word, so m00 lands in the top DW bits.
  function automatic logic [1:0] idx(input logic r, input logic c);
    return 2'd3 - {r, c};
  endfunction

endpackage

// File: rtl/mat_mac_unit.sv
// Registered DW-bit multiply-accumulate; clr restarts the sum, arithmetic wraps modulo 2^DW.
module mat_mac_unit #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          clr,
  input  logic          en,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] prod;
  logic [DW-1:0] base;

  always_comb begin
    prod = a * b;
    base = clr ? '0 : acc;
  end

  // clr together with en starts a fresh sum with this cycle's product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= base + prod;
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/mat2x2_stream_mac.sv
// Streams in A and B, computes A*B on a single MAC over 8 cycles, streams the 4 results out.
module mat2x2_stream_mac
  import mat2x2_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [4*DW-1:0] a_word,
  output logic [4*DW-1:0] b_word,
  output logic [4*DW-1:0] res_word,
  output logic            busy
);

  localparam int SLOTS = N * N;

  state_t        state;
  logic [2:0]    cnt;
  logic [1:0]    dcnt;
  logic [DW-1:0] a_m   [SLOTS];
  logic [DW-1:0] b_m   [SLOTS];
  logic [DW-1:0] res_m [SLOTS];

  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_clr;
  logic          mac_en;
  logic [DW-1:0] acc;

  logic [1:0]    prev_elem;
  logic [1:0]    next_slot;
  logic [DW-1:0] next_data;

  // cnt = {i, j, k} during COMPUTE, so k runs fastest.
  always_comb begin
    mac_a     = a_m[idx(cnt[2], cnt[0])];
    mac_b     = b_m[idx(cnt[0], cnt[1])];
    mac_en    = (state == COMPUTE);
    mac_clr   = (state == COMPUTE) && !cnt[0];
    prev_elem = cnt[2:1] - 2'd1;
    next_slot = 2'd2 - dcnt;
    next_data = (next_slot == 2'd0) ? acc : res_m[next_slot];
  end

  mat_mac_unit #(.DW(DW)) u_mac (
    .clk (clk),
    .rst (rst),
    .a   (mac_a),
    .b   (mac_b),
    .clr (mac_clr),
    .en  (mac_en),
    .acc (acc)
  );

  // r11 is never copied out of the accumulator: it only settles on the last COMPUTE edge.
  assign a_word   = {a_m[3], a_m[2], a_m[1], a_m[0]};
  assign b_word   = {b_m[3], b_m[2], b_m[1], b_m[0]};
  assign res_word = {res_m[3], res_m[2], res_m[1], acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= 3'd0;
      dcnt      <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        a_m[s]   <= '0;
        b_m[s]   <= '0;
        res_m[s] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            if (!cnt[2]) begin
              a_m[idx(cnt[1], cnt[0])] <= in_data;
            end else begin
              b_m[idx(cnt[1], cnt[0])] <= in_data;
            end
            cnt <= cnt + 3'd1;
            if (cnt == 3'(ELEMS_IN - 1)) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          cnt <= cnt + 3'd1;
          // At k=0 the accumulator still holds the element finished on the previous edge.
          if (!cnt[0] && (cnt != 3'd0)) begin
            res_m[idx(prev_elem[1], prev_elem[0])] <= acc;
          end
          if (cnt == 3'(ELEMS_IN - 1)) begin
            state     <= DRAIN;
            dcnt      <= 2'd0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= res_m[3];
          end
        end
        DRAIN: begin
          if (out_ready) begin
            dcnt     <= dcnt + 2'd1;
            out_data <= next_data;
            out_last <= (dcnt == 2'd2);
            if (dcnt == 2'(ELEMS_OUT - 1)) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat2x2_stream_mac.sv
// Directed bench for mat2x2_stream_mac: hand-computed results, backpressure, gaps, resets.
module tb_mat2x2_stream_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic [31:0] res_word;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_last = 0;

  mat2x2_stream_mac #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .a_word    (a_word),
    .b_word    (b_word),
    .res_word  (res_word),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  32'd0);
    chk({tag, "_out_valid"}, out_valid, 32'd0);
    chk({tag, "_out_last"},  out_last,  32'd0);
    chk({tag, "_busy"},      busy,      32'd0);
    chk({tag, "_out_data"},  out_data,  32'd0);
    chk({tag, "_a_word"},    a_word,    32'd0);
    chk({tag, "_b_word"},    b_word,    32'd0);
    chk({tag, "_res_word"},  res_word,  32'd0);
  endtask

  // v holds 8 elements MSB first; gp holds a 4-bit idle gap before each element.
  task automatic load_mat(input logic [63:0] v, input logic [31:0] gp);
    int wt;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b0;
      in_data  = 8'hA5;
      repeat (int'(gp[31-4*n -: 4])) @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[63-8*n -: 8];
      wt = 0;
      while (!in_ready && wt < 40) begin
        @(negedge clk);
        wt++;
      end
      if (!in_ready) begin
        chk("load_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      t_last = cyc;
    end
    in_valid = 1'b0;
    in_data  = 8'h5A;
  endtask

  task automatic wait_valid();
    int wt;
    wt = 0;
    while (!out_valid && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    chk("valid_timeout", out_valid, 32'd1);
  endtask

  task automatic drain(input string tag, input logic [31:0] exp, input int stall);
    wait_valid();
    for (int n = 0; n < 4; n++) begin
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        chk({tag, "_hold_data"}, out_data, exp[31-8*n -: 8]);
        chk({tag, "_hold_valid"}, out_valid, 32'd1);
        chk({tag, "_in_ready_drain"}, in_ready, 32'd0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      chk({tag, "_data"}, out_data, exp[31-8*n -: 8]);
      chk({tag, "_last"}, out_last, (n == 3) ? 32'd1 : 32'd0);
      chk({tag, "_res_word"}, res_word, exp);
      chk({tag, "_busy"}, busy, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, "_in_ready_back"}, in_ready, 32'd1);
    chk({tag, "_valid_low"}, out_valid, 32'd0);
    chk({tag, "_busy_low"}, busy, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready_rise", in_ready, 32'd1);

    // Case 1: basic, with latency check.
    load_mat(64'h01020304_05060708, 32'h0);
    chk("c1_a_word", a_word, 32'h01020304);
    chk("c1_b_word", b_word, 32'h05060708);
    chk("c1_busy", busy, 32'd1);
    chk("c1_in_ready_low", in_ready, 32'd0);
    wait_valid();
    chk("c1_latency", cyc - t_last, 32'd8);
    drain("c1", 32'h13162B32, 0);

    // Overflow cases.
    load_mat({8{8'h10}}, 32'h0);
    drain("ovf16", 32'h00000000, 0);
    load_mat({8{8'hFF}}, 32'h0);
    drain("ovf255", 32'h02020202, 0);

    // Backpressure: 5 stalled cycles on every element.
    load_mat(64'h01020304_05060708, 32'h0);
    drain("bp", 32'h13162B32, 5);

    // Input gaps, latency measured from the last transfer.
    load_mat(64'h01020304_05060708, 32'h02130142);
    chk("gap_a_word", a_word, 32'h01020304);
    wait_valid();
    chk("gap_latency", cyc - t_last, 32'd8);
    drain("gap", 32'h13162B32, 0);

    // Reset during COMPUTE.
    load_mat(64'h01020304_05060708, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_compute");
    rst = 1'b0;
    @(negedge clk);

    // Reset during DRAIN.
    load_mat(64'h01020304_05060708, 32'h0);
    wait_valid();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_drain");
    rst = 1'b0;
    @(negedge clk);
    load_mat(64'h01020304_05060708, 32'h0);
    drain("after_rst", 32'h13162B32, 0);

    // Back-to-back: identity * B, then case 1.
    load_mat(64'h01000001_05060708, 32'h0);
    drain("ident", 32'h05060708, 0);
    load_mat(64'h01020304_05060708, 32'h0);
    drain("b2b", 32'h13162B32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
